// File: rtl/decode_pipe_stage.sv
// Decode stage: register-field extraction, register file with write-first
// bypass, load-use bubble insertion and the ID/EX pipeline register.
module decode_pipe_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int INSTR_WIDTH    = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int CTRL_WIDTH     = 24
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [INSTR_WIDTH-1:0]    i_instr,
    input  logic                      i_instr_valid,
    input  logic [CTRL_WIDTH-1:0]     i_ctrl,
    input  logic                      i_read1,
    input  logic                      i_read2,
    input  logic                      i_mem_read,
    input  logic                      i_hold,
    input  logic                      i_flush,
    input  logic                      i_write_back,
    input  logic [REG_ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    output logic                      o_valid,
    output logic [CTRL_WIDTH-1:0]     o_ctrl,
    output logic                      o_mem_read,
    output logic [DATA_WIDTH-1:0]     o_data1,
    output logic [DATA_WIDTH-1:0]     o_data2,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [REG_ADDR_WIDTH-1:0] o_rs,
    output logic                      o_stall,
    output logic                      o_ready
);

    localparam int NREG   = 1 << REG_ADDR_WIDTH;
    localparam int RD_TOP = INSTR_WIDTH - 4;
    localparam int RS_TOP = RD_TOP - REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     rf_q [NREG];
    logic [REG_ADDR_WIDTH-1:0] rd_f;
    logic [REG_ADDR_WIDTH-1:0] rs_f;
    logic [DATA_WIDTH-1:0]     rdat1;
    logic [DATA_WIDTH-1:0]     rdat2;
    logic                      unused_instr;

    logic                      valid_q, valid_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
    logic                      memrd_q, memrd_d;
    logic [DATA_WIDTH-1:0]     data1_q, data1_d;
    logic [DATA_WIDTH-1:0]     data2_q, data2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;

    assign rd_f         = i_instr[RD_TOP -: REG_ADDR_WIDTH];
    assign rs_f         = i_instr[RS_TOP -: REG_ADDR_WIDTH];
    assign unused_instr = ^i_instr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (i_write_back) begin
            rf_q[i_write_addr] <= i_write_data;
        end
    end

    // Write-first: a same-cycle write is visible to the read port.
    always_comb begin
        rdat1 = '0;
        rdat2 = '0;
        if (i_read1)
            rdat1 = (i_write_back && i_write_addr == rd_f)
                  ? i_write_data : rf_q[rd_f];
        if (i_read2)
            rdat2 = (i_write_back && i_write_addr == rs_f)
                  ? i_write_data : rf_q[rs_f];
    end

    assign o_stall = i_instr_valid & valid_q & memrd_q &
                     ((i_read1 & (rd_f == rd_q)) |
                      (i_read2 & (rs_f == rd_q)));
    assign o_ready = ~o_stall & ~i_hold;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        memrd_d = memrd_q;
        data1_d = data1_q;
        data2_d = data2_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        if (i_flush || (!i_hold && o_stall)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            memrd_d = 1'b0;
            data1_d = '0;
            data2_d = '0;
            rd_d    = '0;
            rs_d    = '0;
        end else if (!i_hold) begin
            valid_d = i_instr_valid;
            ctrl_d  = i_instr_valid ? i_ctrl : '0;
            memrd_d = i_instr_valid & i_mem_read;
            data1_d = rdat1;
            data2_d = rdat2;
            rd_d    = rd_f;
            rs_d    = rs_f;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            memrd_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            memrd_q <= memrd_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_ctrl     = ctrl_q;
    assign o_mem_read = memrd_q;
    assign o_data1    = data1_q;
    assign o_data2    = data2_q;
    assign o_rd       = rd_q;
    assign o_rs       = rs_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: default 16-bit instance plus a
// 32-bit / 16-register instance.
module tb_decode_pipe_stage;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Instance A: default parameters
    logic [15:0] a_instr;
    logic        a_ivalid;
    logic [23:0] a_ctrl;
    logic        a_read1, a_read2, a_memrd;
    logic        a_hold, a_flush, a_wb;
    logic [2:0]  a_waddr;
    logic [15:0] a_wdata;
    logic        a_valid_o, a_memrd_o, a_stall, a_ready;
    logic [23:0] a_ctrl_o;
    logic [15:0] a_d1, a_d2;
    logic [2:0]  a_rd, a_rs;

    decode_pipe_stage u_a (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_instr(a_instr), .i_instr_valid(a_ivalid),
        .i_ctrl(a_ctrl), .i_read1(a_read1), .i_read2(a_read2),
        .i_mem_read(a_memrd), .i_hold(a_hold), .i_flush(a_flush),
        .i_write_back(a_wb), .i_write_addr(a_waddr),
        .i_write_data(a_wdata),
        .o_valid(a_valid_o), .o_ctrl(a_ctrl_o),
        .o_mem_read(a_memrd_o), .o_data1(a_d1), .o_data2(a_d2),
        .o_rd(a_rd), .o_rs(a_rs), .o_stall(a_stall), .o_ready(a_ready)
    );

    // Instance B: 32-bit data, 4-bit register index
    logic [15:0] b_instr;
    logic        b_ivalid;
    logic [23:0] b_ctrl;
    logic        b_read1;
    logic        b_zero = 1'b0;
    logic        b_wb;
    logic [3:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_valid_o, b_memrd_o, b_stall, b_ready;
    logic [23:0] b_ctrl_o;
    logic [31:0] b_d1, b_d2;
    logic [3:0]  b_rd, b_rs;

    decode_pipe_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) u_b (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_instr(b_instr), .i_instr_valid(b_ivalid),
        .i_ctrl(b_ctrl), .i_read1(b_read1), .i_read2(b_zero),
        .i_mem_read(b_zero), .i_hold(b_zero), .i_flush(b_zero),
        .i_write_back(b_wb), .i_write_addr(b_waddr),
        .i_write_data(b_wdata),
        .o_valid(b_valid_o), .o_ctrl(b_ctrl_o),
        .o_mem_read(b_memrd_o), .o_data1(b_d1), .o_data2(b_d2),
        .o_rd(b_rd), .o_rs(b_rs), .o_stall(b_stall), .o_ready(b_ready)
    );

    function automatic logic [15:0] mka(input logic [2:0] rd,
                                        input logic [2:0] rs);
        return {3'b101, rd, rs, 7'h55};
    endfunction

    function automatic logic [15:0] mkb(input logic [3:0] rd,
                                        input logic [3:0] rs);
        return {3'b011, rd, rs, 5'h15};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [2:0] rd,
                           input logic [2:0] rs, input logic r1,
                           input logic r2, input logic ld,
                           input logic [23:0] c);
        a_ivalid = v; a_instr = mka(rd, rs);
        a_read1 = r1; a_read2 = r2; a_memrd = ld; a_ctrl = c;
    endtask

    initial begin
        i_reset = 1'b1;
        a_drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 24'h0);
        a_hold = 0; a_flush = 0; a_wb = 0; a_waddr = 0; a_wdata = 0;
        b_instr = 0; b_ivalid = 0; b_ctrl = 0; b_read1 = 0;
        b_wb = 0; b_waddr = 0; b_wdata = 0;
        #12;
        chk("rst_valid", a_valid_o, 0);
        chk("rst_ctrl", a_ctrl_o, 0);
        chk("rst_d1", a_d1, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_ready", a_ready, 1);
        a_hold = 1; #1;
        chk("rst_ready_hold", a_ready, 0);
        a_hold = 0;
        i_reset = 1'b0;

        // write R3, then read it through rd
        a_wb = 1; a_waddr = 3; a_wdata = 16'h1234;
        tick();
        a_wb = 0;
        a_drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 24'hABCDEF);
        tick();
        chk("r3_valid", a_valid_o, 1);
        chk("r3_d1", a_d1, 16'h1234);
        chk("r3_rd", a_rd, 3);
        chk("r3_ctrl", a_ctrl_o, 24'hABCDEF);

        // same-cycle write/read bypass on rs
        a_wb = 1; a_waddr = 5; a_wdata = 16'hBEEF;
        a_drive(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 24'h000042);
        tick();
        chk("byp_d2", a_d2, 16'hBEEF);
        chk("byp_d1_off", a_d1, 0);
        chk("byp_rs", a_rs, 5);
        a_wb = 0;
        tick();
        chk("r5_stored", a_d2, 16'hBEEF);

        // load to rd=2 then dependent read of rs=2
        a_drive(1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 24'h000777);
        tick();
        chk("ld_memrd", a_memrd_o, 1);
        chk("ld_rd", a_rd, 2);
        a_drive(1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 24'h000111);
        #1;
        chk("lu_stall", a_stall, 1);
        chk("lu_ready", a_ready, 0);
        tick();
        chk("bub_valid", a_valid_o, 0);
        chk("bub_ctrl", a_ctrl_o, 0);
        chk("bub_memrd", a_memrd_o, 0);
        chk("bub_stall", a_stall, 0);
        chk("bub_ready", a_ready, 1);
        tick();
        chk("dep_valid", a_valid_o, 1);
        chk("dep_rs", a_rs, 2);
        chk("dep_ctrl", a_ctrl_o, 24'h000111);

        // hold for three cycles, then flush under hold
        a_hold = 1;
        a_drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 24'h000999);
        #1;
        chk("hold_ready", a_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", a_valid_o, 1);
            chk("hold_ctrl", a_ctrl_o, 24'h000111);
            chk("hold_rs", a_rs, 2);
        end
        a_flush = 1;
        tick();
        chk("flush_valid", a_valid_o, 0);
        chk("flush_ctrl", a_ctrl_o, 0);
        chk("flush_rs", a_rs, 0);
        a_flush = 0; a_hold = 0;

        // invalid slot: ctrl and load flag forced to 0
        a_drive(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 24'h00FFFF);
        tick();
        chk("inv_valid", a_valid_o, 0);
        chk("inv_ctrl", a_ctrl_o, 0);
        chk("inv_memrd", a_memrd_o, 0);

        // load rd=4 (writing R4), then disabled read of rd=4
        a_wb = 1; a_waddr = 4; a_wdata = 16'h5555;
        a_drive(1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 24'h000001);
        tick();
        a_wb = 0;
        a_drive(1'b1, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 24'h000002);
        #1;
        chk("nord_stall", a_stall, 0);
        tick();
        chk("nord_valid", a_valid_o, 1);
        chk("nord_d1", a_d1, 0);
        chk("nord_ctrl", a_ctrl_o, 24'h000002);

        // load then dependent + hold: stall persists only via hold
        a_drive(1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 24'h000003);
        tick();
        a_drive(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 24'h000004);
        a_hold = 1;
        tick();
        chk("hs_valid", a_valid_o, 1);
        chk("hs_stall", a_stall, 1);
        a_hold = 0;
        tick();
        chk("hs_bubble", a_valid_o, 0);
        tick();
        chk("hs_issue", a_ctrl_o, 24'h000004);

        // async reset mid-hold
        a_hold = 1;
        #2 i_reset = 1'b1;
        #1;
        chk("arst_valid", a_valid_o, 0);
        chk("arst_ctrl", a_ctrl_o, 0);
        chk("arst_rd", a_rd, 0);
        #1 i_reset = 1'b0;
        a_hold = 0;
        a_drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 24'h000005);
        tick();
        chk("post_valid", a_valid_o, 1);
        chk("post_rd", a_rd, 4);
        chk("post_d1_clr", a_d1, 0);
        a_drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 24'h0);

        // wide instance: R15
        b_wb = 1; b_waddr = 4'd15; b_wdata = 32'hDEADBEEF;
        tick();
        b_wb = 0;
        b_instr = mkb(4'd15, 4'd0); b_ivalid = 1; b_read1 = 1;
        b_ctrl = 24'h000ABC;
        tick();
        chk("b_d1", b_d1, 32'hDEADBEEF);
        chk("b_rd", b_rd, 15);
        chk("b_valid", b_valid_o, 1);
        #2 i_reset = 1'b1;
        #1;
        chk("b_arst_d1", b_d1, 0);
        chk("b_arst_valid", b_valid_o, 0);
        chk("b_arst_rd", b_rd, 0);
        chk("b_arst_ctrl", b_ctrl_o, 0);
        #1 i_reset = 1'b0;
        tick();
        chk("b_rf_clr", b_d1, 0);
        chk("b_rd_again", b_rd, 15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
